pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor_pkg.sv | 45 ++++
 rtl/pll_lock_supervisor_sync_2ff.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 209 ++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared encodings, register map and bit positions for the PLL lock supervisor.
// Also holds the sizing helpers used for the internal counters.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;

  localparam int unsigned STAT_LOST_BIT     = 2;
  localparam int unsigned STAT_TMO_BIT      = 3;
  localparam int unsigned CTRL_SOFT_RST_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
  localparam int unsigned CTRL_MASK_LSB     = 8;

  // Status register layout, MSB first.
  typedef struct packed {
    logic [7:0] loss_cnt;
    logic       rsvd;
    logic [2:0] state;
    logic       timeout;
    logic       lost_lock;
    logic       run;
    logic       lock;
  } status_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of a counter that must reach n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// 1-bit two-flop synchroniser for an asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock, and holds the system in reset until the
// clock is trusted; exposes status/control over a small Avalon-MM slave.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned NUM_OUT        = 4,
  parameter int unsigned ARESET_CYCLES  = 8,
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned HOLD_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               read,
  input  logic               write,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic               pll_locked,
  output logic               pll_areset,
  output logic               resetrequest,
  output logic               locked,
  output logic [NUM_OUT-1:0] clk_en,
  output logic               irq
);

  localparam int unsigned CNT_W = cnt_width(max3(ARESET_CYCLES, LOCK_FILTER, HOLD_CYCLES));
  localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               lost_q, lost_d, timeout_q, timeout_d;
  logic [7:0]         loss_q, loss_d;
  logic               irq_en_q, irq_en_d;
  logic [NUM_OUT-1:0] mask_q, mask_d;
  logic               lost_set, tmo_set;
  logic               pll_areset_d, resetrequest_d, irq_d;
  logic [NUM_OUT-1:0] clk_en_d;
  logic               lock_s, wr_status, wr_ctrl, soft_rst, clr_lost, clr_tmo;
  status_t            status;
  logic [15:0]        ctrl_rd;
  logic               unused_wdata;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign wr_status    = chipselect & write & (address == ADDR_STATUS);
  assign wr_ctrl      = chipselect & write & (address == ADDR_CTRL);
  assign soft_rst     = wr_ctrl & writedata[CTRL_SOFT_RST_BIT];
  assign clr_lost     = wr_status & writedata[STAT_LOST_BIT];
  assign clr_tmo      = wr_status & writedata[STAT_TMO_BIT];
  assign unused_wdata = ^writedata;
  assign locked       = lock_s & (state_q == ST_RUN);

  // Next-state, counters, sticky flags and next output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    lost_set = 1'b0;
    tmo_set  = 1'b0;

    if (soft_rst) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Timeout counter only advances here and survives filter failures.
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_FILTER;
            cnt_d   = '0;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            tmo_d   = '0;
            tmo_set = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_FILTER: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d  = ST_WAIT_LOCK;
            lost_set = 1'b1;
          end
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end

    // A set event in the same cycle as a W1C wins.
    lost_d    = lost_set | (lost_q & ~clr_lost);
    timeout_d = tmo_set | (timeout_q & ~clr_tmo);
    if (clr_lost) begin
      loss_d = lost_set ? 8'd1 : 8'd0;
    end else if (lost_set && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end

    irq_en_d = wr_ctrl ? writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
    mask_d   = wr_ctrl ? writedata[CTRL_MASK_LSB +: NUM_OUT] : mask_q;

    pll_areset_d   = (state_d == ST_PLL_RST);
    resetrequest_d = (state_d != ST_RUN);
    clk_en_d       = (state_d == ST_RUN) ? mask_d : '0;
    irq_d          = irq_en_d & (lost_d | timeout_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      tmo_q        <= '0;
      lost_q       <= 1'b0;
      timeout_q    <= 1'b0;
      loss_q       <= '0;
      irq_en_q     <= 1'b0;
      mask_q       <= '1;
      pll_areset   <= 1'b1;
      resetrequest <= 1'b1;
      clk_en       <= '0;
      irq          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      lost_q       <= lost_d;
      timeout_q    <= timeout_d;
      loss_q       <= loss_d;
      irq_en_q     <= irq_en_d;
      mask_q       <= mask_d;
      pll_areset   <= pll_areset_d;
      resetrequest <= resetrequest_d;
      clk_en       <= clk_en_d;
      irq          <= irq_d;
    end
  end

  // Zero-latency read mux; soft-reset bit always reads back 0.
  always_comb begin
    status           = '0;
    status.lock      = lock_s;
    status.run       = (state_q == ST_RUN);
    status.lost_lock = lost_q;
    status.timeout   = timeout_q;
    status.state     = state_q;
    status.loss_cnt  = loss_q;

    ctrl_rd                              = '0;
    ctrl_rd[CTRL_IRQ_EN_BIT]             = irq_en_q;
    ctrl_rd[CTRL_MASK_LSB +: NUM_OUT]    = mask_q;

    readdata = '0;
    if (chipselect && read) begin
      case (address)
        ADDR_STATUS: readdata = status;
        ADDR_CTRL:   readdata = ctrl_rd;
        default:     readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: register vector table plus hand-timed
// sequences for bring-up, loss, filter glitch, soft reset, timeout and saturation.
module tb_pll_lock_supervisor;

  localparam int ARESET  = 8;
  localparam int FILT    = 16;
  localparam int HOLD    = 64;
  localparam int TMO     = 100;
  // lock_s is already high on WAIT_LOCK entry (synchroniser settles during PLL_RST),
  // so one WAIT_LOCK cycle, then the full filter and hold windows.
  localparam int RUN_LAT = 1 + FILT + HOLD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, read, write;
  logic [15:0] writedata, readdata;
  logic        pll_locked, pll_areset, resetrequest, locked, irq;
  logic [3:0]  clk_en;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        cs;
    logic        wr;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr;
    logic [15:0] exp_rd;
    logic [3:0]  exp_en;
  } vec_t;

  vec_t vecs [8];

  pll_lock_supervisor #(
    .NUM_OUT        (4),
    .ARESET_CYCLES  (ARESET),
    .LOCK_FILTER    (FILT),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .pll_locked   (pll_locked),
    .pll_areset   (pll_areset),
    .resetrequest (resetrequest),
    .locked       (locked),
    .clk_en       (clk_en),
    .irq          (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return !resetrequest;
      1:       return pll_areset;
      default: return !pll_areset;
    endcase
  endfunction

  // which: 0 = RUN reached, 1 = pll_areset asserted, 2 = pll_areset released
  task automatic wait_for(input string name, input int which, input int budget);
    int n;
    n = 0;
    while (!cond(which) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_reached"}, 16'(cond(which)), 16'h0001);
  endtask

  task automatic drop_lock_one_cycle();
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int t0;

    vecs[0] = '{1'b1, 1'b1, 3'd1, 16'h0A02, 3'd1, 16'h0A02, 4'hA};
    vecs[1] = '{1'b0, 1'b1, 3'd1, 16'h0300, 3'd1, 16'h0A02, 4'hA};
    vecs[2] = '{1'b1, 1'b0, 3'd1, 16'h0300, 3'd1, 16'h0A02, 4'hA};
    vecs[3] = '{1'b1, 1'b1, 3'd2, 16'h0300, 3'd2, 16'h0000, 4'hA};
    vecs[4] = '{1'b1, 1'b1, 3'd1, 16'hF6F0, 3'd1, 16'h0600, 4'h6};
    vecs[5] = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 16'h0000, 4'h6};
    vecs[6] = '{1'b1, 1'b1, 3'd0, 16'h000C, 3'd0, 16'h0043, 4'h6};
    vecs[7] = '{1'b1, 1'b1, 3'd1, 16'h0F00, 3'd1, 16'h0F00, 4'hF};

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 16'h0;
    pll_locked = 1'b1;
    tick(2);

    // Reset state
    check("rst_pll_areset", 16'(pll_areset), 16'h1);
    check("rst_resetrequest", 16'(resetrequest), 16'h1);
    check("rst_locked", 16'(locked), 16'h0);
    check("rst_clk_en", 16'(clk_en), 16'h0);
    check("rst_irq", 16'(irq), 16'h0);
    csr_read(3'd0, rd);
    check("rst_status", rd, 16'h0000);
    csr_read(3'd1, rd);
    check("rst_ctrl", rd, 16'h0F00);

    // Bring-up with lock held high
    tick(1);
    reset_n = 1'b1;
    t0 = cyc;
    wait_for("bringup_areset_fall", 2, 100);
    check("bringup_areset_len", 16'(cyc - t0), 16'(ARESET));
    csr_read(3'd0, rd);
    check("bringup_wait_lock_status", rd, 16'h0011);
    t0 = cyc;
    wait_for("bringup_run", 0, 300);
    check("bringup_run_latency", 16'(cyc - t0), 16'(RUN_LAT));
    check("bringup_clk_en", 16'(clk_en), 16'h000F);
    check("bringup_locked", 16'(locked), 16'h1);
    csr_read(3'd0, rd);
    check("bringup_status", rd, 16'h0043);

    // Register vector table, applied while in RUN
    for (int i = 0; i < 8; i++) begin
      chipselect = vecs[i].cs;
      write      = vecs[i].wr;
      address    = vecs[i].waddr;
      writedata  = vecs[i].wdata;
      tick(1);
      chipselect = 1'b0;
      write      = 1'b0;
      csr_read(vecs[i].raddr, rd);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_clk_en", i), 16'(clk_en), 16'(vecs[i].exp_en));
    end

    // One-cycle lock loss in RUN, then W1C of lost_lock
    drop_lock_one_cycle();
    tick(2);
    check("loss_resetrequest", 16'(resetrequest), 16'h1);
    check("loss_locked", 16'(locked), 16'h0);
    check("loss_clk_en", 16'(clk_en), 16'h0);
    csr_read(3'd0, rd);
    check("loss_status", rd, 16'h0115);
    csr_write(3'd0, 16'h0004);
    csr_read(3'd0, rd);
    check("loss_w1c_status", rd, 16'h0021);
    wait_for("loss_relock", 0, 300);

    // Filter glitch at filter count 10 restarts the filter from scratch
    drop_lock_one_cycle();
    tick(3);
    tick(8);
    drop_lock_one_cycle();
    tick(1);
    csr_read(3'd0, rd);
    check("glitch_still_filter", 16'(rd[6:4]), 16'h0002);
    tick(1);
    csr_read(3'd0, rd);
    check("glitch_back_wait_lock", 16'(rd[6:4]), 16'h0001);
    t0 = cyc;
    wait_for("glitch_run", 0, 300);
    check("glitch_run_latency", 16'(cyc - t0), 16'(RUN_LAT));

    // Soft PLL reset from RUN with a new mask
    csr_write(3'd1, 16'h0501);
    t0 = cyc;
    check("soft_pll_areset", 16'(pll_areset), 16'h1);
    check("soft_clk_en", 16'(clk_en), 16'h0);
    csr_read(3'd0, rd);
    check("soft_state", 16'(rd[6:4]), 16'h0000);
    wait_for("soft_run", 0, 300);
    check("soft_run_latency", 16'(cyc - t0), 16'(ARESET + RUN_LAT));
    check("soft_clk_en_run", 16'(clk_en), 16'h0005);
    csr_read(3'd1, rd);
    check("soft_ctrl_rd", rd, 16'h0500);

    // Lock timeout with interrupts enabled
    csr_write(3'd0, 16'h000C);
    csr_write(3'd1, 16'h0502);
    check("tmo_irq_idle", 16'(irq), 16'h0);
    csr_read(3'd0, rd);
    check("tmo_pre_status", rd, 16'h0043);
    pll_locked = 1'b0;
    tick(3);
    t0 = cyc;
    csr_read(3'd0, rd);
    check("tmo_enter_wait", 16'(rd[6:4]), 16'h0001);
    check("tmo_irq_lost", 16'(irq), 16'h1);
    csr_write(3'd0, 16'h0004);
    check("tmo_irq_cleared", 16'(irq), 16'h0);
    wait_for("tmo_areset", 1, 300);
    check("tmo_wait_len", 16'(cyc - t0), 16'(TMO));
    csr_read(3'd0, rd);
    check("tmo_status", rd, 16'h0008);
    check("tmo_irq", 16'(irq), 16'h1);
    pll_locked = 1'b1;
    wait_for("tmo_relock", 0, 300);
    csr_write(3'd0, 16'h0008);
    check("tmo_irq_w1c", 16'(irq), 16'h0);
    csr_read(3'd0, rd);
    check("tmo_w1c_status", rd, 16'h0043);

    // 300 losses saturate the loss counter at 255
    for (int i = 0; i < 300; i++) begin
      drop_lock_one_cycle();
      tick(2);
      wait_for_quiet: begin
        int n;
        n = 0;
        while (resetrequest && n < 300) begin
          tick(1);
          n++;
        end
      end
      if (resetrequest) break;
    end
    check("sat_relock", 16'(resetrequest), 16'h0);
    csr_read(3'd0, rd);
    check("sat_status", rd, 16'hFF47);
    check("sat_irq", 16'(irq), 16'h1);

    // W1C coinciding with a loss: set wins, counter restarts at 1
    drop_lock_one_cycle();
    tick(1);
    csr_write(3'd0, 16'h0004);
    csr_read(3'd0, rd);
    check("w1c_vs_loss_status", rd, 16'h0115);
    check("w1c_vs_loss_irq", 16'(irq), 16'h1);

    // Asynchronous reset mid-filter aborts the sequence
    tick(5);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_pll_areset", 16'(pll_areset), 16'h1);
    check("midrst_resetrequest", 16'(resetrequest), 16'h1);
    check("midrst_clk_en", 16'(clk_en), 16'h0);
    check("midrst_irq", 16'(irq), 16'h0);
    csr_read(3'd0, rd);
    check("midrst_status", rd, 16'h0000);
    csr_read(3'd1, rd);
    check("midrst_ctrl", rd, 16'h0F00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    t0 = cyc;
    wait_for("midrst_areset_fall", 2, 100);
    check("midrst_areset_len", 16'(cyc - t0), 16'(ARESET));
    t0 = cyc;
    wait_for("midrst_run", 0, 300);
    check("midrst_run_latency", 16'(cyc - t0), 16'(RUN_LAT));
    check("midrst_clk_en_run", 16'(clk_en), 16'h000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
